tl_fragmenter_arbiter: RTL and testbench

- Two-client TileLink-UH arbiter that shares the single upstream A/D port of the fragmenter wrapper (28-bit address, 64-bit data, 3-bit source) between two masters.
- Each client has a 2-bit source. The arbiter prepends the client id as source bit 2 and routes D responses back by that bit.
- Round-robin grant, locked for multi-beat Put bursts, stable while the fragmenter back-pressures.
- Per-client in-flight limit, so one client cannot exhaust the fragmenter's source space.

---
 rtl/tl_fragmenter_arbiter.sv | 214 +++++++++++++++++++++
 tb/tb_tl_fragmenter_arbiter.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tl_fragmenter_arbiter.sv
// Purpose: two-client TileLink-UH arbiter sharing one fragmenter A/D port; client id becomes source bit 2.
// Latency: zero-cycle combinational A and D paths; grant, lock, beat and in-flight state are registered.
// Backpressure: out_a_ready goes only to the granted client, and the grant and payload hold while it is low;
//               D is routed by source[2], and that client's d_ready drives out_d_ready.
//
// Ports:
//   clock, reset                      sole clock, synchronous active-high reset
//   in0_a_* / in1_a_*                 client A channels (2-bit source)
//   in0_d_* / in1_d_*                 client D channels (2-bit source)
//   out_a_*                           merged A channel to the fragmenter (3-bit source)
//   out_d_*                           D channel from the fragmenter (3-bit source)
module tl_fragmenter_arbiter #(
    parameter int MAX_INFLIGHT = 4,
    parameter int BEAT_BYTES   = 8
) (
    input  logic        clock,
    input  logic        reset,

    input  logic        in0_a_valid,
    output logic        in0_a_ready,
    input  logic [2:0]  in0_a_bits_opcode,
    input  logic [2:0]  in0_a_bits_param,
    input  logic [2:0]  in0_a_bits_size,
    input  logic [1:0]  in0_a_bits_source,
    input  logic [27:0] in0_a_bits_address,
    input  logic [7:0]  in0_a_bits_mask,
    input  logic [63:0] in0_a_bits_data,
    input  logic        in0_a_bits_corrupt,
    input  logic        in0_d_ready,
    output logic        in0_d_valid,
    output logic [2:0]  in0_d_bits_opcode,
    output logic [2:0]  in0_d_bits_size,
    output logic [1:0]  in0_d_bits_source,
    output logic [63:0] in0_d_bits_data,

    input  logic        in1_a_valid,
    output logic        in1_a_ready,
    input  logic [2:0]  in1_a_bits_opcode,
    input  logic [2:0]  in1_a_bits_param,
    input  logic [2:0]  in1_a_bits_size,
    input  logic [1:0]  in1_a_bits_source,
    input  logic [27:0] in1_a_bits_address,
    input  logic [7:0]  in1_a_bits_mask,
    input  logic [63:0] in1_a_bits_data,
    input  logic        in1_a_bits_corrupt,
    input  logic        in1_d_ready,
    output logic        in1_d_valid,
    output logic [2:0]  in1_d_bits_opcode,
    output logic [2:0]  in1_d_bits_size,
    output logic [1:0]  in1_d_bits_source,
    output logic [63:0] in1_d_bits_data,

    output logic        out_a_valid,
    input  logic        out_a_ready,
    output logic [2:0]  out_a_bits_opcode,
    output logic [2:0]  out_a_bits_param,
    output logic [2:0]  out_a_bits_size,
    output logic [2:0]  out_a_bits_source,
    output logic [27:0] out_a_bits_address,
    output logic [7:0]  out_a_bits_mask,
    output logic [63:0] out_a_bits_data,
    output logic        out_a_bits_corrupt,

    input  logic        out_d_valid,
    output logic        out_d_ready,
    input  logic [2:0]  out_d_bits_opcode,
    input  logic [2:0]  out_d_bits_size,
    input  logic [2:0]  out_d_bits_source,
    input  logic [63:0] out_d_bits_data
);

    localparam int BEAT_SHIFT = $clog2(BEAT_BYTES);

    // Index of the last beat of a message of the given size (beats - 1), capped at 8 beats.
    function automatic logic [2:0] last_beat(input logic [2:0] size);
        logic [3:0] s;
        s = {1'b0, size};
        if (s <= 4'(BEAT_SHIFT))
            return 3'd0;
        else if ((s - 4'(BEAT_SHIFT)) >= 4'd3)
            return 3'd7;
        else
            return 3'((4'd1 << (s - 4'(BEAT_SHIFT))) - 4'd1);
    endfunction

    function automatic logic [2:0] next_count(input logic [2:0] cnt, input logic inc, input logic dec);
        logic [2:0] r;
        r = cnt;
        if (inc && !dec)
            r = cnt + 3'd1;
        else if (dec && !inc)
            r = (cnt == 3'd0) ? 3'd0 : cnt - 3'd1;
        return r;
    endfunction

    logic       prio;
    logic       locked;
    logic       grant_q;
    logic       grant;
    logic [2:0] a_beat;
    logic [2:0] d_beat;
    logic [2:0] inflight0;
    logic [2:0] inflight1;

    logic       elig0, elig1;
    logic       a_fire, a_first, a_last, a_multi;
    logic [2:0] a_last_idx;
    logic       d_id, d_fire, d_last;
    logic [2:0] d_last_idx;
    logic       inc0, inc1, dec0, dec1;

    // Mid-message beats are never blocked by the in-flight limit: the credit was taken on beat 0.
    assign elig0 = in0_a_valid && ((inflight0 < 3'(MAX_INFLIGHT)) || (a_beat != 3'd0));
    assign elig1 = in1_a_valid && ((inflight1 < 3'(MAX_INFLIGHT)) || (a_beat != 3'd0));

    always_comb begin
        grant = 1'b0;
        if (locked)
            grant = grant_q;
        else if (elig0 && elig1)
            grant = prio;
        else
            grant = elig1;
    end

    assign out_a_bits_opcode  = grant ? in1_a_bits_opcode  : in0_a_bits_opcode;
    assign out_a_bits_param   = grant ? in1_a_bits_param   : in0_a_bits_param;
    assign out_a_bits_size    = grant ? in1_a_bits_size    : in0_a_bits_size;
    assign out_a_bits_source  = {grant, grant ? in1_a_bits_source : in0_a_bits_source};
    assign out_a_bits_address = grant ? in1_a_bits_address : in0_a_bits_address;
    assign out_a_bits_mask    = grant ? in1_a_bits_mask    : in0_a_bits_mask;
    assign out_a_bits_data    = grant ? in1_a_bits_data    : in0_a_bits_data;
    assign out_a_bits_corrupt = grant ? in1_a_bits_corrupt : in0_a_bits_corrupt;

    assign out_a_valid = !reset && (grant ? elig1 : elig0);

    // Ready is also gated by eligibility, so a client held off by its credit limit
    // can never complete a handshake that is not forwarded downstream.
    assign in0_a_ready = !reset && !grant && elig0 && out_a_ready;
    assign in1_a_ready = !reset &&  grant && elig1 && out_a_ready;

    assign a_fire     = out_a_valid && out_a_ready;
    assign a_multi    = (out_a_bits_opcode[2:1] == 2'b00);   // PutFull / PutPartial
    assign a_last_idx = a_multi ? last_beat(out_a_bits_size) : 3'd0;
    assign a_first    = (a_beat == 3'd0);
    assign a_last     = (a_beat == a_last_idx);

    // D routing by the client id carried in source bit 2.
    assign d_id        = out_d_bits_source[2];
    assign out_d_ready = !reset && (d_id ? in1_d_ready : in0_d_ready);
    assign in0_d_valid = !reset && out_d_valid && !d_id;
    assign in1_d_valid = !reset && out_d_valid &&  d_id;

    assign in0_d_bits_opcode = out_d_bits_opcode;
    assign in0_d_bits_size   = out_d_bits_size;
    assign in0_d_bits_source = out_d_bits_source[1:0];
    assign in0_d_bits_data   = out_d_bits_data;
    assign in1_d_bits_opcode = out_d_bits_opcode;
    assign in1_d_bits_size   = out_d_bits_size;
    assign in1_d_bits_source = out_d_bits_source[1:0];
    assign in1_d_bits_data   = out_d_bits_data;

    assign d_fire     = out_d_valid && out_d_ready;
    assign d_last_idx = (out_d_bits_opcode == 3'd1) ? last_beat(out_d_bits_size) : 3'd0;
    assign d_last     = (d_beat == d_last_idx);

    assign inc0 = a_fire && a_first && !grant;
    assign inc1 = a_fire && a_first &&  grant;
    assign dec0 = d_fire && d_last  && !d_id;
    assign dec1 = d_fire && d_last  &&  d_id;

    always_ff @(posedge clock) begin
        if (reset) begin
            prio      <= 1'b0;
            locked    <= 1'b0;
            grant_q   <= 1'b0;
            a_beat    <= 3'd0;
            d_beat    <= 3'd0;
            inflight0 <= 3'd0;
            inflight1 <= 3'd0;
        end else begin
            if (!locked && out_a_valid)
                grant_q <= grant;

            if (a_fire) begin
                if (a_last) begin
                    a_beat <= 3'd0;
                    locked <= 1'b0;
                    prio   <= ~grant;
                end else begin
                    a_beat <= a_beat + 3'd1;
                    locked <= 1'b1;
                end
            end else if (out_a_valid) begin
                // Offered but stalled: freeze the grant until the beat is taken.
                locked <= 1'b1;
            end else if (a_beat == 3'd0) begin
                // Requester withdrew between messages; release the grant.
                locked <= 1'b0;
            end

            if (d_fire)
                d_beat <= d_last ? 3'd0 : d_beat + 3'd1;

            inflight0 <= next_count(inflight0, inc0, dec0);
            inflight1 <= next_count(inflight1, inc1, dec1);
        end
    end

    // A response for a client with nothing outstanding means the downstream misrouted it.
    assert property (@(posedge clock) disable iff (reset) !(dec0 && inflight0 == 3'd0));
    assert property (@(posedge clock) disable iff (reset) !(dec1 && inflight1 == 3'd0));

endmodule

// File: tb/tb_tl_fragmenter_arbiter.sv
module tb_tl_fragmenter_arbiter;

    logic        clock = 1'b0;
    logic        reset;

    logic        in0_a_valid, in0_a_ready;
    logic [2:0]  in0_a_bits_opcode, in0_a_bits_param, in0_a_bits_size;
    logic [1:0]  in0_a_bits_source;
    logic [27:0] in0_a_bits_address;
    logic [7:0]  in0_a_bits_mask;
    logic [63:0] in0_a_bits_data;
    logic        in0_a_bits_corrupt;
    logic        in0_d_ready, in0_d_valid;
    logic [2:0]  in0_d_bits_opcode, in0_d_bits_size;
    logic [1:0]  in0_d_bits_source;
    logic [63:0] in0_d_bits_data;

    logic        in1_a_valid, in1_a_ready;
    logic [2:0]  in1_a_bits_opcode, in1_a_bits_param, in1_a_bits_size;
    logic [1:0]  in1_a_bits_source;
    logic [27:0] in1_a_bits_address;
    logic [7:0]  in1_a_bits_mask;
    logic [63:0] in1_a_bits_data;
    logic        in1_a_bits_corrupt;
    logic        in1_d_ready, in1_d_valid;
    logic [2:0]  in1_d_bits_opcode, in1_d_bits_size;
    logic [1:0]  in1_d_bits_source;
    logic [63:0] in1_d_bits_data;

    logic        out_a_valid, out_a_ready;
    logic [2:0]  out_a_bits_opcode, out_a_bits_param, out_a_bits_size, out_a_bits_source;
    logic [27:0] out_a_bits_address;
    logic [7:0]  out_a_bits_mask;
    logic [63:0] out_a_bits_data;
    logic        out_a_bits_corrupt;
    logic        out_d_valid, out_d_ready;
    logic [2:0]  out_d_bits_opcode, out_d_bits_size, out_d_bits_source;
    logic [63:0] out_d_bits_data;

    tl_fragmenter_arbiter #(.MAX_INFLIGHT(4), .BEAT_BYTES(8)) dut (
        .clock(clock), .reset(reset),
        .in0_a_valid(in0_a_valid), .in0_a_ready(in0_a_ready),
        .in0_a_bits_opcode(in0_a_bits_opcode), .in0_a_bits_param(in0_a_bits_param),
        .in0_a_bits_size(in0_a_bits_size), .in0_a_bits_source(in0_a_bits_source),
        .in0_a_bits_address(in0_a_bits_address), .in0_a_bits_mask(in0_a_bits_mask),
        .in0_a_bits_data(in0_a_bits_data), .in0_a_bits_corrupt(in0_a_bits_corrupt),
        .in0_d_ready(in0_d_ready), .in0_d_valid(in0_d_valid),
        .in0_d_bits_opcode(in0_d_bits_opcode), .in0_d_bits_size(in0_d_bits_size),
        .in0_d_bits_source(in0_d_bits_source), .in0_d_bits_data(in0_d_bits_data),
        .in1_a_valid(in1_a_valid), .in1_a_ready(in1_a_ready),
        .in1_a_bits_opcode(in1_a_bits_opcode), .in1_a_bits_param(in1_a_bits_param),
        .in1_a_bits_size(in1_a_bits_size), .in1_a_bits_source(in1_a_bits_source),
        .in1_a_bits_address(in1_a_bits_address), .in1_a_bits_mask(in1_a_bits_mask),
        .in1_a_bits_data(in1_a_bits_data), .in1_a_bits_corrupt(in1_a_bits_corrupt),
        .in1_d_ready(in1_d_ready), .in1_d_valid(in1_d_valid),
        .in1_d_bits_opcode(in1_d_bits_opcode), .in1_d_bits_size(in1_d_bits_size),
        .in1_d_bits_source(in1_d_bits_source), .in1_d_bits_data(in1_d_bits_data),
        .out_a_valid(out_a_valid), .out_a_ready(out_a_ready),
        .out_a_bits_opcode(out_a_bits_opcode), .out_a_bits_param(out_a_bits_param),
        .out_a_bits_size(out_a_bits_size), .out_a_bits_source(out_a_bits_source),
        .out_a_bits_address(out_a_bits_address), .out_a_bits_mask(out_a_bits_mask),
        .out_a_bits_data(out_a_bits_data), .out_a_bits_corrupt(out_a_bits_corrupt),
        .out_d_valid(out_d_valid), .out_d_ready(out_d_ready),
        .out_d_bits_opcode(out_d_bits_opcode), .out_d_bits_size(out_d_bits_size),
        .out_d_bits_source(out_d_bits_source), .out_d_bits_data(out_d_bits_data)
    );

    always #5 clock = ~clock;

    int n_chk = 0;
    int n_bad = 0;

    // Client A inputs in the table are always single-beat Gets of size 3.
    typedef struct {
        logic       v0, v1, oar, dv, dr0, dr1;
        logic [2:0] dop, dsz, dsrc;
        logic       e_oav, e_ar0, e_ar1, e_dv0, e_dv1, e_odr;
        logic [2:0] e_src;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic clear_inputs();
        in0_a_valid = 0; in0_a_bits_opcode = 3'd4; in0_a_bits_param = 0; in0_a_bits_size = 3'd3;
        in0_a_bits_source = 2'd2; in0_a_bits_address = 28'h100; in0_a_bits_mask = 8'hff;
        in0_a_bits_data = 64'h0; in0_a_bits_corrupt = 0; in0_d_ready = 1;
        in1_a_valid = 0; in1_a_bits_opcode = 3'd4; in1_a_bits_param = 0; in1_a_bits_size = 3'd3;
        in1_a_bits_source = 2'd1; in1_a_bits_address = 28'h200; in1_a_bits_mask = 8'hff;
        in1_a_bits_data = 64'h0; in1_a_bits_corrupt = 0; in1_d_ready = 1;
        out_a_ready = 0;
        out_d_valid = 0; out_d_bits_opcode = 0; out_d_bits_size = 0; out_d_bits_source = 0;
        out_d_bits_data = 64'h0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        clear_inputs();
        reset = 1;
        @(negedge clock);
        reset = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1;
        clear_inputs();

        // Reset state: everything quiet while reset is high.
        @(negedge clock);
        in0_a_valid = 1; in1_a_valid = 1; out_a_ready = 1; out_d_valid = 1;
        #1;
        chk("reset_out_a_valid", out_a_valid, 0);
        chk("reset_in0_a_ready", in0_a_ready, 0);
        chk("reset_in1_a_ready", in1_a_ready, 0);
        chk("reset_in0_d_valid", in0_d_valid, 0);
        chk("reset_out_d_ready", out_d_ready, 0);

        // ---- Single Get with AccessAckData return ----
        do_reset();
        @(negedge clock);
        in0_a_valid = 1; out_a_ready = 1;
        #1;
        chk("get_out_a_valid", out_a_valid, 1);
        chk("get_out_a_source", out_a_bits_source, 3'b010);
        chk("get_out_a_address", out_a_bits_address, 28'h100);
        @(negedge clock);
        in0_a_valid = 0; out_a_ready = 0;
        out_d_valid = 1; out_d_bits_opcode = 3'd1; out_d_bits_size = 3'd3;
        out_d_bits_source = 3'b010; out_d_bits_data = 64'hDEADBEEF;
        #1;
        chk("get_inflight0_one", dut.inflight0, 1);
        chk("get_in0_d_valid", in0_d_valid, 1);
        chk("get_in0_d_source", in0_d_bits_source, 2'd2);
        chk("get_in0_d_data", in0_d_bits_data, 64'hDEADBEEF);
        chk("get_in1_d_valid", in1_d_valid, 0);
        @(negedge clock);
        out_d_valid = 0;
        #1;
        chk("get_inflight0_zero", dut.inflight0, 0);

        // ---- Table: alternation, D routing, D multi-beat, concurrent A/D ----
        //            v0 v1 oar dv dr0 dr1 dop dsz dsrc | oav ar0 ar1 dv0 dv1 odr src
        vecs[0] = '{1, 1, 1, 0, 1, 1, 3'd0, 3'd0, 3'd0, 1, 1, 0, 0, 0, 1, 3'b010};
        vecs[1] = '{1, 1, 1, 0, 1, 1, 3'd0, 3'd0, 3'd0, 1, 0, 1, 0, 0, 1, 3'b101};
        vecs[2] = '{1, 1, 1, 0, 1, 1, 3'd0, 3'd0, 3'd0, 1, 1, 0, 0, 0, 1, 3'b010};
        vecs[3] = '{1, 1, 1, 0, 1, 1, 3'd0, 3'd0, 3'd0, 1, 0, 1, 0, 0, 1, 3'b101};
        vecs[4] = '{0, 0, 0, 1, 1, 1, 3'd1, 3'd4, 3'd7, 0, 0, 0, 0, 1, 1, 3'b000};
        vecs[5] = '{0, 0, 0, 1, 1, 0, 3'd1, 3'd4, 3'd7, 0, 0, 0, 0, 1, 0, 3'b000};
        vecs[6] = '{0, 0, 0, 1, 1, 1, 3'd1, 3'd4, 3'd7, 0, 0, 0, 0, 1, 1, 3'b000};
        vecs[7] = '{1, 0, 1, 1, 1, 1, 3'd0, 3'd6, 3'd0, 1, 1, 0, 1, 0, 1, 3'b010};
        vecs[8] = '{0, 0, 0, 1, 0, 1, 3'd0, 3'd3, 3'd1, 0, 0, 0, 1, 0, 0, 3'b000};
        do_reset();
        for (int i = 0; i < 9; i++) begin
            @(negedge clock);
            in0_a_valid = vecs[i].v0; in1_a_valid = vecs[i].v1; out_a_ready = vecs[i].oar;
            out_d_valid = vecs[i].dv; in0_d_ready = vecs[i].dr0; in1_d_ready = vecs[i].dr1;
            out_d_bits_opcode = vecs[i].dop; out_d_bits_size = vecs[i].dsz;
            out_d_bits_source = vecs[i].dsrc; out_d_bits_data = 64'(i) + 64'h1000;
            #1;
            chk($sformatf("vec%0d_out_a_valid", i), out_a_valid, vecs[i].e_oav);
            chk($sformatf("vec%0d_in0_a_ready", i), in0_a_ready, vecs[i].e_ar0);
            chk($sformatf("vec%0d_in1_a_ready", i), in1_a_ready, vecs[i].e_ar1);
            chk($sformatf("vec%0d_in0_d_valid", i), in0_d_valid, vecs[i].e_dv0);
            chk($sformatf("vec%0d_in1_d_valid", i), in1_d_valid, vecs[i].e_dv1);
            chk($sformatf("vec%0d_out_d_ready", i), out_d_ready, vecs[i].e_odr);
            if (vecs[i].e_oav) begin
                chk($sformatf("vec%0d_out_a_source", i), out_a_bits_source, vecs[i].e_src);
                chk($sformatf("vec%0d_out_a_address", i), out_a_bits_address,
                    vecs[i].e_src[2] ? 28'h200 : 28'h100);
            end
            if (vecs[i].e_dv1) begin
                chk($sformatf("vec%0d_in1_d_source", i), in1_d_bits_source, vecs[i].dsrc[1:0]);
                chk($sformatf("vec%0d_in1_d_data", i), in1_d_bits_data, 64'(i) + 64'h1000);
            end
        end
        @(negedge clock);
        clear_inputs();
        #1;
        chk("table_inflight0", dut.inflight0, 2);
        chk("table_inflight1", dut.inflight1, 1);

        // ---- Burst lock: 8-beat PutFull from in0 with in1 waiting ----
        do_reset();
        for (int b = 0; b < 8; b++) begin
            @(negedge clock);
            in0_a_valid = 1; in0_a_bits_opcode = 3'd0; in0_a_bits_size = 3'd6;
            in0_a_bits_data = 64'(b) + 64'hA0;
            in1_a_valid = 1; out_a_ready = 1;
            #1;
            chk($sformatf("burst%0d_in1_a_ready", b), in1_a_ready, 0);
            chk($sformatf("burst%0d_in0_a_ready", b), in0_a_ready, 1);
            chk($sformatf("burst%0d_out_a_data", b), out_a_bits_data, 64'(b) + 64'hA0);
        end
        @(negedge clock);
        in0_a_valid = 0;
        #1;
        chk("burst_after_in1_a_ready", in1_a_ready, 1);
        chk("burst_after_source", out_a_bits_source, 3'b101);

        // ---- Credit limit: in1 saturates at 4 outstanding ----
        do_reset();
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            in1_a_valid = 1; out_a_ready = 1;
            #1;
            chk($sformatf("credit%0d_in1_a_ready", k), in1_a_ready, 1);
        end
        @(negedge clock);
        in0_a_valid = 1;
        #1;
        chk("credit5_in1_a_ready", in1_a_ready, 0);
        chk("credit5_in0_a_ready", in0_a_ready, 1);
        @(negedge clock);
        out_d_valid = 1; out_d_bits_opcode = 3'd0; out_d_bits_size = 3'd3;
        out_d_bits_source = 3'b100;
        #1;
        chk("credit_d_in1_d_valid", in1_d_valid, 1);
        chk("credit_d_in1_a_ready", in1_a_ready, 0);
        @(negedge clock);
        out_d_valid = 0;
        #1;
        chk("credit_after_in1_a_ready", in1_a_ready, 1);
        chk("credit_after_source", out_a_bits_source, 3'b101);

        // ---- Back-pressure: grant and payload hold while out_a_ready is low ----
        do_reset();
        @(negedge clock);
        in0_a_valid = 1; out_a_ready = 1;          // one fire moves prio to in1
        @(negedge clock);
        out_a_ready = 0;
        #1;
        chk("bp_out_a_valid", out_a_valid, 1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            in1_a_valid = 1;
            #1;
            chk($sformatf("bp%0d_source", k), out_a_bits_source, 3'b010);
            chk($sformatf("bp%0d_address", k), out_a_bits_address, 28'h100);
            chk($sformatf("bp%0d_in1_a_ready", k), in1_a_ready, 0);
            chk($sformatf("bp%0d_in0_a_ready", k), in0_a_ready, 0);
        end
        @(negedge clock);
        out_a_ready = 1;
        #1;
        chk("bp_release_in0_a_ready", in0_a_ready, 1);
        chk("bp_release_source", out_a_bits_source, 3'b010);
        @(negedge clock);
        #1;
        chk("bp_next_source", out_a_bits_source, 3'b101);

        // ---- Reset in the middle of a burst ----
        do_reset();
        for (int b = 0; b < 3; b++) begin
            @(negedge clock);
            in0_a_valid = 1; in0_a_bits_opcode = 3'd0; in0_a_bits_size = 3'd6; out_a_ready = 1;
        end
        @(negedge clock);
        reset = 1;
        out_d_valid = 1; out_d_bits_source = 3'b000;
        #1;
        chk("rst_mid_locked_before", dut.locked, 1);
        chk("rst_mid_out_a_valid", out_a_valid, 0);
        chk("rst_mid_in0_a_ready", in0_a_ready, 0);
        chk("rst_mid_in0_d_valid", in0_d_valid, 0);
        chk("rst_mid_out_d_ready", out_d_ready, 0);
        @(negedge clock);
        #1;
        chk("rst_mid_prio", dut.prio, 0);
        chk("rst_mid_locked", dut.locked, 0);
        chk("rst_mid_inflight0", dut.inflight0, 0);
        chk("rst_mid_inflight1", dut.inflight1, 0);
        chk("rst_mid_a_beat", dut.a_beat, 0);
        chk("rst_mid_out_a_valid_held", out_a_valid, 0);
        reset = 0;
        out_d_valid = 0;
        #1;
        chk("rst_mid_restart_valid", out_a_valid, 1);
        @(negedge clock);
        clear_inputs();

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
        $finish;
    end

endmodule
